// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - traffic-light phase FSM driving an external interval timer
// Each timed phase loads timer_value, pulses start_timer and advances on the timer's expired rising edge.
module light_sequencer #(
  parameter logic [3:0] T_MAIN_GREEN = 4'd10,
  parameter logic [3:0] T_YELLOW     = 4'd3,
  parameter logic [3:0] T_ALL_RED    = 4'd1,
  parameter logic [3:0] T_SIDE_GREEN = 4'd6,
  parameter logic [4:0] WDOG_TICKS   = 5'd20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       one_hz_enable_i,
  input  logic       side_car_i,
  input  logic       expired_i,
  output logic       start_timer_o,
  output logic [3:0] timer_value_o,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       fault_o
);

  if (T_MAIN_GREEN == 4'd0 || T_YELLOW == 4'd0 || T_ALL_RED == 4'd0 ||
      T_SIDE_GREEN == 4'd0 || WDOG_TICKS <= 5'd16) begin : g_bad_param
    $error("light_sequencer: zero interval or WDOG_TICKS <= 16");
  end

  typedef enum logic [3:0] {
    S_INIT, S_MAIN_GREEN, S_MAIN_HOLD, S_MAIN_YELLOW, S_RED_A,
    S_SIDE_GREEN, S_SIDE_YELLOW, S_RED_B, S_FAULT
  } state_t;

  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  state_t     state_q, state_d;
  logic       enter_d;
  logic       armed_q;
  logic [4:0] wdog_q;
  logic       start_q, fault_q;
  logic [3:0] value_q;
  logic [2:0] main_q, side_q;
  logic       exp_s1_q, exp_s2_q, exp_s3_q;
  logic       car_s1_q, car_s2_q;
  logic       exp_rise, timed, wdog_fire;

  // Synchronisers are deliberately not reset so a level held high through reset never looks like a new edge.
  always_ff @(posedge clk_i) begin
    exp_s1_q <= expired_i;
    exp_s2_q <= exp_s1_q;
    exp_s3_q <= exp_s2_q;
    car_s1_q <= side_car_i;
    car_s2_q <= car_s1_q;
  end

  assign exp_rise  = exp_s2_q & ~exp_s3_q;
  assign timed     = (state_q != S_MAIN_HOLD) && (state_q != S_FAULT);
  assign wdog_fire = timed && one_hz_enable_i && (wdog_q == WDOG_TICKS - 5'd1);

  function automatic logic [3:0] interval_of(input state_t s);
    case (s)
      S_MAIN_GREEN:                 interval_of = T_MAIN_GREEN;
      S_MAIN_YELLOW, S_SIDE_YELLOW: interval_of = T_YELLOW;
      S_SIDE_GREEN:                 interval_of = T_SIDE_GREEN;
      default:                      interval_of = T_ALL_RED;
    endcase
  endfunction

  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      S_MAIN_GREEN, S_MAIN_HOLD: lamps_of = {GRN, RED};
      S_MAIN_YELLOW:             lamps_of = {YEL, RED};
      S_SIDE_GREEN:              lamps_of = {RED, GRN};
      S_SIDE_YELLOW:             lamps_of = {RED, YEL};
      default:                   lamps_of = {RED, RED};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!armed_q) begin
          enter_d = 1'b1;
        end else if (exp_rise) begin
          state_d = S_MAIN_GREEN;
          enter_d = 1'b1;
        end
      end
      S_MAIN_GREEN: begin
        if (exp_rise) begin
          state_d = car_s2_q ? S_MAIN_YELLOW : S_MAIN_HOLD;
          enter_d = car_s2_q;
        end
      end
      S_MAIN_HOLD: begin
        if (car_s2_q) begin
          state_d = S_MAIN_YELLOW;
          enter_d = 1'b1;
        end
      end
      S_MAIN_YELLOW: if (exp_rise) begin state_d = S_RED_A;       enter_d = 1'b1; end
      S_RED_A:       if (exp_rise) begin state_d = S_SIDE_GREEN;  enter_d = 1'b1; end
      S_SIDE_GREEN:  if (exp_rise) begin state_d = S_SIDE_YELLOW; enter_d = 1'b1; end
      S_SIDE_YELLOW: if (exp_rise) begin state_d = S_RED_B;       enter_d = 1'b1; end
      S_RED_B:       if (exp_rise) begin state_d = S_MAIN_GREEN;  enter_d = 1'b1; end
      S_FAULT:       state_d = S_FAULT;
      default:       state_d = S_FAULT;
    endcase
    // A completion on the same edge as the last allowed tick takes precedence over the watchdog.
    if (wdog_fire && !enter_d && state_d == state_q) begin
      state_d = S_FAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      armed_q <= 1'b0;
      wdog_q  <= 5'd0;
      start_q <= 1'b0;
      value_q <= 4'd0;
      main_q  <= RED;
      side_q  <= RED;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      start_q <= enter_d;
      if (enter_d) begin
        value_q <= interval_of(state_d);
        wdog_q  <= 5'd0;
      end else if (timed && one_hz_enable_i && wdog_q != WDOG_TICKS) begin
        wdog_q <= wdog_q + 5'd1;
      end
      if (state_d == S_FAULT) begin
        fault_q <= 1'b1;
        if (state_q != S_FAULT) begin
          main_q <= RED;
          side_q <= RED;
        end else if (one_hz_enable_i) begin
          main_q <= main_q ^ RED;
          side_q <= side_q ^ RED;
        end
      end else begin
        {main_q, side_q} <= lamps_of(state_d);
      end
    end
  end

  assign start_timer_o = start_q;
  assign timer_value_o = value_q;
  assign main_light_o  = main_q;
  assign side_light_o  = side_q;
  assign fault_o       = fault_q;

endmodule
